// File: rtl/chess_clock_pkg.sv
// Shared types and constants for the chess-clock display path.
// Latency: none (types, constants and a pure decode function only).
// Backpressure: not applicable.
package chess_clock_pkg;

   // Display geometry: two players, four digits each, one shared scan.
   localparam int N_DIGITS          = 8;
   localparam int DIGITS_PER_PLAYER = 4;

   // One 7-segment code, active-low segments.
   typedef logic [6:0] seg_t;

   // Digit index within a full frame.
   typedef logic [2:0] idx_t;

   // Anode vector, active-low.
   typedef logic [N_DIGITS-1:0] an_t;

   localparam seg_t SEG_BLANK = 7'h7F;
   localparam an_t  AN_OFF    = 8'hFF;

   // One-hot-low anode pattern selecting a single digit.
   function automatic an_t anode_decode(input idx_t idx);
      an_t an;
      an      = AN_OFF;
      an[idx] = 1'b0;
      return an;
   endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Modulo-DIV slot counter with clock enable and terminal-count pulse.
// Latency: cnt is registered; tc is combinational from cnt and ce.
// Backpressure: ce=0 freezes the count; tc is only asserted while ce=1.
module scan_prescaler
   #(
      parameter  int unsigned DIV = 4,
      localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1
   ) (
      input  logic          clk,
      input  logic          clr,
      input  logic          ce,
      output logic [CW-1:0] cnt,
      output logic          tc
   );

   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   // Terminal count only counts as an event when the scan is enabled.
   assign tc = ce && (cnt == LAST);

   // Count 0..DIV-1 while enabled; clear wins over enable.
   always_ff @(posedge clk) begin
      if (clr) begin
         cnt <= '0;
      end else if (ce) begin
         if (tc) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/seg_scan_mux.sv
// Scans both players' 4-digit 7-seg codes onto one 8-digit display with per-slot blanking.
// Latency: AN/SEG registered, 1 cycle after (cnt, idx); input codes appear from the next frame.
// Backpressure: CE=0 freezes the scan and holds the current digit. Optional OVERFLOW_BLINK_EN.
module seg_scan_mux
   import chess_clock_pkg::*;
   #(
      parameter int unsigned SCAN_DIV     = 50000,
      parameter int unsigned BLANK_CYCLES = 500,
      parameter int unsigned BLINK_FRAMES = 64
   ) (
      input  logic       CLK,
      input  logic       CLR,
      input  logic       CE,
      input  logic [6:0] seg0_0,
      input  logic [6:0] seg0_1,
      input  logic [6:0] seg0_2,
      input  logic [6:0] seg0_3,
      input  logic [6:0] seg1_0,
      input  logic [6:0] seg1_1,
      input  logic [6:0] seg1_2,
      input  logic [6:0] seg1_3,
      input  logic       OVERFLOW1,
      input  logic       OVERFLOW2,
      output logic [7:0] AN,
      output logic [6:0] SEG
   );

   localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic [CW-1:0] cnt;
   logic          slot_end;
   idx_t          idx;
   logic          snap;
   seg_t          shadow [N_DIGITS];
   an_t           an_next;

   scan_prescaler #(
      .DIV (SCAN_DIV)
   ) u_slot_timer (
      .clk (CLK),
      .clr (CLR),
      .ce  (CE),
      .cnt (cnt),
      .tc  (slot_end)
   );

   // The last enabled cycle of digit 7 closes the frame and latches the next one.
   assign snap = slot_end && (idx == idx_t'(N_DIGITS - 1));

   // Digit index advances at each slot end and wraps naturally from 7 to 0.
   always_ff @(posedge CLK) begin
      if (CLR) begin
         idx <= '0;
      end else if (slot_end) begin
         idx <= idx + idx_t'(1);
      end
   end

   // Frame snapshot: codes only change at a frame boundary so a scan never tears.
   always_ff @(posedge CLK) begin
      if (CLR) begin
         for (int i = 0; i < N_DIGITS; i++) begin
            shadow[i] <= SEG_BLANK;
         end
      end else if (snap) begin
         shadow[0]                     <= seg0_0;
         shadow[1]                     <= seg0_1;
         shadow[2]                     <= seg0_2;
         shadow[3]                     <= seg0_3;
         shadow[DIGITS_PER_PLAYER + 0] <= seg1_0;
         shadow[DIGITS_PER_PLAYER + 1] <= seg1_1;
         shadow[DIGITS_PER_PLAYER + 2] <= seg1_2;
         shadow[DIGITS_PER_PLAYER + 3] <= seg1_3;
      end
   end

`ifdef OVERFLOW_BLINK_EN
   localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [FW-1:0] frame_cnt;
   logic          blink_phase;
   logic [1:0]    shadow_ovf;

   // Overflow flags share the frame snapshot; the blink phase flips every BLINK_FRAMES frames.
   always_ff @(posedge CLK) begin
      if (CLR) begin
         frame_cnt   <= '0;
         blink_phase <= 1'b0;
         shadow_ovf  <= 2'b00;
      end else if (snap) begin
         shadow_ovf <= {OVERFLOW2, OVERFLOW1};
         if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
            frame_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            frame_cnt <= frame_cnt + FW'(1);
         end
      end
   end
`else
   // Overflow inputs and the blink period have no effect in this build.
   logic unused_cfg;
   assign unused_cfg = OVERFLOW1 ^ OVERFLOW2 ^ BLINK_FRAMES[0];
`endif

   // Anode pattern for the current slot: dark during the leading blank window.
   always_comb begin
      an_next = (32'(cnt) < BLANK_CYCLES) ? AN_OFF : anode_decode(idx);
`ifdef OVERFLOW_BLINK_EN
      if (blink_phase && shadow_ovf[0]) begin
         an_next[DIGITS_PER_PLAYER-1:0] = '1;
      end
      if (blink_phase && shadow_ovf[1]) begin
         an_next[N_DIGITS-1:DIGITS_PER_PLAYER] = '1;
      end
`endif
   end

   // Registered display outputs so nothing reaches the pins combinationally.
   always_ff @(posedge CLK) begin
      if (CLR) begin
         AN  <= AN_OFF;
         SEG <= SEG_BLANK;
      end else begin
         AN  <= an_next;
         SEG <= shadow[idx];
      end
   end

endmodule
